// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Big-endian byte lane select (offset 0 is the MSB lane), sign-extended to a word.
    function automatic logic [WORD_W-1:0] byte_sext(input logic [WORD_W-1:0] word,
                                                    input logic [1:0]        sel);
        logic [BYTE_W-1:0] b;
        b = word[31:24];
        case (sel)
            2'd0: b = word[31:24];
            2'd1: b = word[23:16];
            2'd2: b = word[15:8];
            2'd3: b = word[7:0];
        endcase
        return {{(WORD_W-BYTE_W){b[BYTE_W-1]}}, b};
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word array with synchronous write and asynchronous read; contents are never reset.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] a,
    input  logic [WORD_W-1:0]        wd,
    output logic [WORD_W-1:0]        rd
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[a] <= wd;
        end
    end

    assign rd = mem[a];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave: one request at a time, fixed access latency, registered response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q, write_d;
    logic              byte_q, byte_d;
    logic [AW+1:0]     addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [WORD_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic              misalign_c;
    logic              ram_we_c;
    logic [WORD_W-1:0] ram_rd;

    // Address bits above the word index only alias; they are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^req_addr[WORD_W-1:AW+2];

    // A byte offset is only legal on byte loads; stores are always word-sized.
    assign misalign_c = (write_q || !byte_q) && (addr_q[1:0] != 2'b00);

    dmem_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk (clk),
        .we  (ram_we_c),
        .a   (addr_q[AW+1:2]),
        .wd  (wdata_q),
        .rd  (ram_rd)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        byte_d       = byte_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        ram_we_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    byte_d  = req_byte;
                    addr_d  = req_addr[AW+1:0];
                    wdata_d = req_wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    ram_we_c     = write_q && !misalign_c;
                    resp_valid_d = 1'b1;
                    resp_err_d   = misalign_c;
                    if (write_q || misalign_c) begin
                        resp_rdata_d = '0;
                    end else if (byte_q) begin
                        resp_rdata_d = byte_sext(ram_rd, addr_q[1:0]);
                    end else begin
                        resp_rdata_d = ram_rd;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            byte_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            byte_q       <= byte_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized checks of dmem_responder against an array-based memory model.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned LAT   = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [DEPTH];

    dmem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_byte   (req_byte),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: word array indexed modulo DEPTH, big-endian byte lanes.
    task automatic model(input logic w, input logic b, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic e);
        int          idx;
        int          lo;
        logic        mis;
        logic [7:0]  byt;
        idx = int'((a / 4) % DEPTH);
        lo  = int'(a % 4);
        mis = (w || !b) && (lo != 0);
        e   = mis;
        rd  = 32'h0;
        if (w) begin
            if (!mis) mdl[idx] = wd;
        end else if (!mis) begin
            if (b) begin
                byt = 8'((mdl[idx] >> (8 * (3 - lo))) & 32'hFF);
                rd  = 32'($signed(byt));
            end else begin
                rd = mdl[idx];
            end
        end
    endtask

    // One full transaction; bp = cycles of response backpressure, pulse = stray request during bp.
    task automatic xact(input logic w, input logic b, input logic [31:0] a,
                        input logic [31:0] wd, input int bp, input logic pulse);
        logic [31:0] exp_rd;
        logic        exp_e;
        int          n;
        model(w, b, a, wd, exp_rd, exp_e);
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_byte  = b;
        req_addr  = a;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = $urandom;
        req_addr  = $urandom;
        n = 0;
        while (resp_valid !== 1'b1 && n < 30) begin
            check("req_ready_busy", 32'(req_ready), 32'd0);
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(LAT));
        check("rdata", resp_rdata, exp_rd);
        check("err", 32'(resp_err), 32'(exp_e));
        for (int i = 0; i < bp; i++) begin
            if (pulse && i == 1) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_byte  = 1'b0;
                req_addr  = 32'h40;
                req_wdata = 32'hBADC0FFE;
            end
            @(negedge clk);
            req_valid = 1'b0;
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_rdata", resp_rdata, exp_rd);
            check("bp_err", 32'(resp_err), 32'(exp_e));
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("consumed_valid", 32'(resp_valid), 32'd0);
        check("consumed_req_ready", 32'(req_ready), 32'd1);
        if (pulse) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("no_extra_resp", 32'(resp_valid), 32'd0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_byte   = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        reset = 1'b1;

        // Fill every word so the model knows all contents.
        for (int i = 0; i < int'(DEPTH); i++) begin
            xact(1'b1, 1'b0, 32'(i * 4), $urandom, 0, 1'b0);
        end

        xact(1'b1, 1'b0, 32'h10, 32'h12345678, 0, 1'b0);
        xact(1'b0, 1'b0, 32'h10, 32'h0, 0, 1'b0);

        xact(1'b1, 1'b0, 32'h20, 32'h80FF7F01, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            xact(1'b0, 1'b1, 32'(32'h20 + i), 32'h0, 0, 1'b0);
        end

        xact(1'b1, 1'b0, 32'h22, 32'hDEADBEEF, 0, 1'b0);
        xact(1'b0, 1'b0, 32'h20, 32'h0, 0, 1'b0);
        xact(1'b0, 1'b0, 32'h21, 32'h0, 0, 1'b0);

        xact(1'b0, 1'b0, 32'h10, 32'h0, 5, 1'b1);
        xact(1'b0, 1'b0, 32'h40, 32'h0, 0, 1'b0);

        // Abort a store mid-WAIT; the previous load leaves nonzero rdata to be cleared.
        xact(1'b0, 1'b0, 32'h20, 32'h0, 0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_byte  = 1'b0;
        req_addr  = 32'h30;
        req_wdata = 32'hAAAAAAAA;
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_resp_rdata", resp_rdata, 32'd0);
        check("abort_resp_err", 32'(resp_err), 32'd0);
        @(negedge clk);
        check("abort_idle_valid", 32'(resp_valid), 32'd0);
        xact(1'b0, 1'b0, 32'h30, 32'h0, 0, 1'b0);

        xact(1'b1, 1'b0, 32'h100, 32'h5, 0, 1'b0);
        xact(1'b0, 1'b0, 32'h000, 32'h0, 0, 1'b0);

        for (int i = 0; i < 120; i++) begin
            xact(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 1023)), $urandom, $urandom_range(0, 3), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
